// File: rtl/pair_invariant_checker.sv
// Run-time checker for a two-signal invariant on the a/b pair.
// Counts samples and violations and captures the first failure.
module pair_invariant_checker #(
    parameter int CNT_W        = 16,
    parameter int MODE         = 0,
    parameter int HALT_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             err,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] first_fail_cycle,
    output logic [1:0]       first_fail_ab,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t cur, nxt;
    logic   bad;
    logic   sample;
    logic   viol;

    always_comb begin
        bad = (MODE == 1) ? ~(a | b) : ~(a ^ b);
    end

    assign sample = ((cur == ARMED) || (cur == FAILED)) && en && !clr;
    assign viol   = sample && bad;
    assign state  = cur;

    always_comb begin
        nxt = cur;
        if (clr) begin
            nxt = en ? ARMED : IDLE;
        end else begin
            unique case (cur)
                IDLE: begin
                    // re-enabling resumes in the state matching the sticky flag
                    if (en) nxt = err ? FAILED : ARMED;
                end
                ARMED, FAILED: begin
                    if (!en)
                        nxt = IDLE;
                    else if (bad)
                        nxt = (HALT_ON_FAIL != 0) ? HALTED : FAILED;
                end
                HALTED: nxt = HALTED;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err              <= 1'b0;
            fail_pulse       <= 1'b0;
            cycle_cnt        <= '0;
            viol_cnt         <= '0;
            first_fail_cycle <= '0;
            first_fail_ab    <= 2'b00;
        end else begin
            fail_pulse <= viol;
            if (sample && (cycle_cnt != CNT_MAX))
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (viol) begin
                if (viol_cnt != CNT_MAX)
                    viol_cnt <= viol_cnt + CNT_ONE;
                if (!err) begin
                    err              <= 1'b1;
                    first_fail_cycle <= cycle_cnt;
                    first_fail_ab    <= {a, b};
                end
            end
        end
    end

endmodule

// File: tb/tb_pair_invariant_checker.sv
// Bench for pair_invariant_checker: four parameter variants on shared
// stimulus, checked every cycle against a behavioural model.
module tb_pair_invariant_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr, a, b;

    logic        e0, e1, e2, e3;
    logic        p0, p1, p2, p3;
    logic [15:0] c0, c1, c2, v0, v1, v2, f0, f1, f2;
    logic [3:0]  c3, v3, f3;
    logic [1:0]  ab0, ab1, ab2, ab3;
    logic [1:0]  s0, s1, s2, s3;

    pair_invariant_checker #(.CNT_W(16), .MODE(0), .HALT_ON_FAIL(0)) d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .err(e0), .fail_pulse(p0), .cycle_cnt(c0), .viol_cnt(v0),
        .first_fail_cycle(f0), .first_fail_ab(ab0), .state(s0));

    pair_invariant_checker #(.CNT_W(16), .MODE(1), .HALT_ON_FAIL(0)) d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .err(e1), .fail_pulse(p1), .cycle_cnt(c1), .viol_cnt(v1),
        .first_fail_cycle(f1), .first_fail_ab(ab1), .state(s1));

    pair_invariant_checker #(.CNT_W(16), .MODE(0), .HALT_ON_FAIL(1)) d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .err(e2), .fail_pulse(p2), .cycle_cnt(c2), .viol_cnt(v2),
        .first_fail_cycle(f2), .first_fail_ab(ab2), .state(s2));

    pair_invariant_checker #(.CNT_W(4), .MODE(0), .HALT_ON_FAIL(0)) d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .err(e3), .fail_pulse(p3), .cycle_cnt(c3), .viol_cnt(v3),
        .first_fail_cycle(f3), .first_fail_ab(ab3), .state(s3));

    // per-instance model parameters
    int mode_p [4] = '{0, 1, 0, 0};
    int halt_p [4] = '{0, 0, 1, 0};
    int max_p  [4] = '{65535, 65535, 65535, 15};

    // model: session active / halted flags instead of an encoded state
    int       m_cyc [4];
    int       m_vio [4];
    int       m_ffc [4];
    bit [1:0] m_ab  [4];
    bit       m_err [4];
    bit       m_pls [4];
    bit       m_act [4];
    bit       m_hlt [4];
    bit       started = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] o_cyc [4], o_vio [4], o_ffc [4], o_ab [4];
    logic [31:0] o_err [4], o_pls [4], o_st [4];

    always_comb begin
        o_cyc[0] = 32'(c0); o_cyc[1] = 32'(c1);
        o_cyc[2] = 32'(c2); o_cyc[3] = 32'(c3);
        o_vio[0] = 32'(v0); o_vio[1] = 32'(v1);
        o_vio[2] = 32'(v2); o_vio[3] = 32'(v3);
        o_ffc[0] = 32'(f0); o_ffc[1] = 32'(f1);
        o_ffc[2] = 32'(f2); o_ffc[3] = 32'(f3);
        o_ab[0]  = 32'(ab0); o_ab[1] = 32'(ab1);
        o_ab[2]  = 32'(ab2); o_ab[3] = 32'(ab3);
        o_err[0] = 32'(e0); o_err[1] = 32'(e1);
        o_err[2] = 32'(e2); o_err[3] = 32'(e3);
        o_pls[0] = 32'(p0); o_pls[1] = 32'(p1);
        o_pls[2] = 32'(p2); o_pls[3] = 32'(p3);
        o_st[0]  = 32'(s0); o_st[1] = 32'(s1);
        o_st[2]  = 32'(s2); o_st[3] = 32'(s3);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_wipe(int i);
        m_cyc[i] = 0;
        m_vio[i] = 0;
        m_ffc[i] = 0;
        m_ab[i]  = 2'b00;
        m_err[i] = 1'b0;
        m_pls[i] = 1'b0;
        m_hlt[i] = 1'b0;
    endfunction

    function automatic void model_step(int i);
        bit bad;
        if (!rst_n) begin
            model_wipe(i);
            m_act[i] = 1'b0;
        end else if (clr) begin
            model_wipe(i);
            m_act[i] = en;
        end else if (m_hlt[i]) begin
            m_pls[i] = 1'b0;
        end else if (!m_act[i]) begin
            m_pls[i] = 1'b0;
            m_act[i] = en;
        end else if (!en) begin
            m_pls[i] = 1'b0;
            m_act[i] = 1'b0;
        end else begin
            bad = (mode_p[i] == 1) ? (!a && !b) : (a == b);
            m_pls[i] = bad;
            if (bad) begin
                if (!m_err[i]) begin
                    m_err[i] = 1'b1;
                    m_ffc[i] = m_cyc[i];
                    m_ab[i]  = {a, b};
                end
                if (m_vio[i] < max_p[i]) m_vio[i]++;
                if (halt_p[i] != 0) m_hlt[i] = 1'b1;
            end
            if (m_cyc[i] < max_p[i]) m_cyc[i]++;
        end
    endfunction

    function automatic int model_state(int i);
        if (m_hlt[i]) return 3;
        if (!m_act[i]) return 0;
        return m_err[i] ? 2 : 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) model_step(i);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("d%0d cycle_cnt", i), o_cyc[i], m_cyc[i]);
                chk($sformatf("d%0d viol_cnt", i), o_vio[i], m_vio[i]);
                chk($sformatf("d%0d first_fail_cycle", i), o_ffc[i], m_ffc[i]);
                chk($sformatf("d%0d first_fail_ab", i), o_ab[i], 32'(m_ab[i]));
                chk($sformatf("d%0d err", i), o_err[i], 32'(m_err[i]));
                chk($sformatf("d%0d fail_pulse", i), o_pls[i], 32'(m_pls[i]));
                chk($sformatf("d%0d state", i), o_st[i], model_state(i));
            end
        end
    end

    task automatic cyc(input bit r, input bit e, input bit c, input bit [1:0] ab);
        @(negedge clk);
        rst_n = r;
        en    = e;
        clr   = c;
        {a, b} = ab;
        @(posedge clk);
        #1;
    endtask

    bit [1:0] seq [10] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10,
                           2'b11, 2'b01, 2'b10, 2'b10, 2'b10};
    bit [1:0] hseq [4] = '{2'b01, 2'b10, 2'b00, 2'b00};

    initial begin
        int  pcnt;
        bit  pl [10];
        bit  r, e, c;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        a     = 1'($urandom);
        b     = 1'($urandom);

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'($urandom));
        chk("reset state", 32'(s0), 0);
        chk("reset cycle_cnt", 32'(c0), 0);
        chk("reset err", 32'(e0), 0);
        chk("reset fail_pulse", 32'(p0), 0);

        cyc(1'b1, 1'b1, 1'b0, 2'b01);
        chk("arm edge cycle_cnt", 32'(c0), 0);
        chk("arm edge state", 32'(s0), 1);

        pcnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 1'b0, seq[k]);
            pl[k] = p0;
            pcnt += int'(p0);
        end
        chk("mode0 viol_cnt", 32'(v0), 4);
        chk("mode0 cycle_cnt", 32'(c0), 10);
        chk("mode0 first_fail_cycle", 32'(f0), 0);
        chk("mode0 first_fail_ab", 32'(ab0), 0);
        chk("mode0 err", 32'(e0), 1);
        chk("mode0 pulse count", 32'(pcnt), 4);
        chk("mode0 pulse run", {30'd0, pl[2], pl[3]}, 3);
        chk("mode1 viol_cnt", 32'(v1), 1);
        chk("mode1 first_fail_cycle", 32'(f1), 0);
        chk("mode1 state", 32'(s1), 2);

        cyc(1'b1, 1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, hseq[k]);
            if (k == 2) chk("halt state after sample 2", 32'(s2), 3);
        end
        chk("halt viol_cnt", 32'(v2), 1);
        chk("halt cycle_cnt", 32'(c2), 3);
        chk("halt state held", 32'(s2), 3);
        cyc(1'b1, 1'b1, 1'b1, 2'b00);
        chk("halt clr state", 32'(s2), 1);
        chk("halt clr cycle_cnt", 32'(c2), 0);
        chk("halt clr viol_cnt", 32'(v2), 0);

        repeat (20) cyc(1'b1, 1'b1, 1'b0, 2'b00);
        chk("sat cycle_cnt", 32'(c3), 15);
        chk("sat viol_cnt", 32'(v3), 15);
        chk("sat first_fail_cycle", 32'(f3), 0);
        chk("wide cycle_cnt", 32'(c0), 20);

        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'b00);
            chk("gap fail_pulse", 32'(p0), 0);
        end
        chk("gap cycle_cnt", 32'(c0), 20);
        chk("gap viol_cnt", 32'(v0), 20);
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        chk("reenable state", 32'(s0), 2);
        cyc(1'b1, 1'b1, 1'b1, 2'b00);
        chk("clr collision viol_cnt", 32'(v0), 0);
        chk("clr collision err", 32'(e0), 0);
        chk("clr collision fail_pulse", 32'(p0), 0);
        chk("clr collision state", 32'(s0), 1);

        repeat (3000) begin
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 29) == 0);
            cyc(r, e, c, 2'($urandom));
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pair_invariant_checker.md
# pair_invariant_checker

Synthesizable run-time checker for a two-signal invariant on the `a`/`b` stimulus pair. Each enabled clock it samples `a` and `b`, tests the selected invariant, and reports violations. It counts sampled cycles and violations, and captures the first failing cycle and its `a`/`b` values. It sits at the receiving end of the pair and gives hardware and emulation builds the same pass/fail visibility that the simulation bench gets from its concurrent property.

## Interface
Parameters:
- `CNT_W`, 16: width of `cycle_cnt`, `viol_cnt` and `first_fail_cycle`.
- `MODE`, 0: invariant select. 0 requires `a ^ b == 1`; 1 requires `a | b == 1` (at least one of the two high).
- `HALT_ON_FAIL`, 0: 1 stops sampling after the first violation.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: sampling enable.
- `clr` in 1: synchronous clear of counters, flags and capture registers.
- `a` in 1: monitored signal A.
- `b` in 1: monitored signal B.
- `err` out 1: sticky violation flag.
- `fail_pulse` out 1: one-cycle pulse per detected violation.
- `cycle_cnt` out `CNT_W`: number of sampled cycles, saturating.
- `viol_cnt` out `CNT_W`: number of violations, saturating.
- `first_fail_cycle` out `CNT_W`: `cycle_cnt` value at the first violating sample.
- `first_fail_ab` out 2: `{a,b}` at the first violation.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = FAILED, 3 = HALTED.

## Operation
- **Reset** (`rst_n` = 0 at a rising edge) drives every output to 0 and the state to IDLE.
- **Priority:** `rst_n`, then `clr`, then sampling.
- **Clear:** `clr` = 1 has the same effect as reset, except that state goes to ARMED if `en` = 1 and to IDLE otherwise. The sample taken in a `clr` cycle is discarded.
- **Sample cycle:** the state is ARMED or FAILED, `en` = 1, `clr` = 0.
- **Violation:** a sample cycle whose sample fails the invariant. `MODE` 0 flags `{a,b}` = 00 or 11. `MODE` 1 flags 00 only.
- **Each sample cycle:** `cycle_cnt` increments, saturating at 2^`CNT_W`−1.
- **On a violation:**
  - `viol_cnt` increments (saturating) and `fail_pulse` asserts next cycle.
  - If `err` was 0: `err` is set, `first_fail_cycle` takes the pre-increment `cycle_cnt`, and `first_fail_ab` takes `{a,b}`. Both captures are held until clear.
- **State transitions:**
  - IDLE → ARMED when `en` = 1.
  - ARMED → FAILED on a violation. If `HALT_ON_FAIL` = 1, ARMED → HALTED instead.
  - FAILED keeps sampling.
  - ARMED or FAILED → IDLE when `en` = 0. Counters and flags are held; re-enabling returns to ARMED if `err` = 0 and to FAILED if `err` = 1.
  - HALTED is left only by `clr` or reset; `en` is ignored there.
- **Saturation:** counters stop at all-ones and never wrap. `err` is unaffected.

## Timing
- `a` and `b` are sampled at the rising edge. All outputs are registered, so results are visible one cycle after the sampling edge.
- `fail_pulse` is high for exactly one cycle per violation. Back-to-back violations hold it high continuously.
- First sample: the first rising edge with `en` = 1 only moves IDLE → ARMED. Sampling starts on the following edge, so the first sample has index 0.
- `en` deassertion takes effect on the same edge: that cycle is not sampled.
- `clr` together with a violation: clear wins and no pulse is issued.
- Reset asserted mid-run: all state is lost on that edge; there is no partial capture.
- `rst_n` and `clr` are synchronous only. Their assertion has no effect between clock edges.

## Test plan
- **Reset values:** hold `rst_n` = 0 for 3 cycles with random `a`/`b` → all outputs 0, `state` = 0.
- **MODE 0, 10 samples:** `{a,b}` = 00, 01, 11, 11, 10, 11, 01, 10, 10, 10 → `viol_cnt` = 4, `cycle_cnt` = 10, `first_fail_cycle` = 0, `first_fail_ab` = 00, `err` = 1, four `fail_pulse` cycles including a 2-cycle run for samples 2–3.
- **MODE 1, same sequence:** → `viol_cnt` = 1, `first_fail_cycle` = 0, and `state` ends at 2.
- **HALT_ON_FAIL = 1:** samples 01, 10, 00, 00 → `state` = 3 after sample 2, `viol_cnt` = 1, `cycle_cnt` = 3. Then `clr` with `en` = 1 → `state` = 1 and counters 0.
- **Saturation with `CNT_W` = 4:** 20 consecutive 00 samples in MODE 0 → `cycle_cnt` = 15, `viol_cnt` = 15, `first_fail_cycle` = 0.
- **Enable gap and clear collision:** deassert `en` for 3 cycles mid-run with violating inputs → counters unchanged and no pulse. Assert `clr` in the same cycle as a violating sample → `viol_cnt` = 0, `err` = 0, no `fail_pulse`.
